storage_arbiter: RTL and testbench

- Shares the single request/response port of the storage controller (SRAM cache plus external SPI storage) between two requesters: port 0 = scalar core data port, port 1 = vector unit memory port.
- Round-robin, one outstanding transaction at a time.
- Latches the winning request, holds it stable downstream until the storage controller signals completion, then returns registered data to the winner.
- Sits between the MMU-side requesters and the storage controller.

---
 rtl/storage_arb_pkg.sv | 24 ++
 rtl/rr_arbiter2.sv | 36 +++
 rtl/storage_arbiter.sv | 174 +++++++++++++++++
 tb/tb_storage_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/storage_arb_pkg.sv
// Shared types for the storage arbiter: FSM state encoding, port ids and
// the latched downstream request record.
package storage_arb_pkg;

  localparam int ARB_MEM_W = 32;
  localparam int ARB_BE_W  = ARB_MEM_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  localparam logic PORT_SCALAR = 1'b0;
  localparam logic PORT_VECTOR = 1'b1;

  typedef struct packed {
    logic                is_writing;
    logic [31:0]         addr;
    logic [31:0]         d_in;
    logic [ARB_BE_W-1:0] be;
  } mem_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. The grant is combinational; the priority
// pointer is registered and, when update_en is high and a grant is made,
// moves to the port that did not win.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update_en,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic ptr_q;

  // Lone requester wins outright; a tie goes to the pointer.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = 1'b0;
    unique case (req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ptr_q;
      default: gnt_id = 1'b0;
    endcase
  end

  // Pointer hands priority to the other port after every grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (update_en && gnt_valid) begin
      ptr_q <= ~gnt_id;
    end
  end

endmodule

// File: rtl/storage_arbiter.sv
// Shares the storage controller port between the scalar core (port 0) and
// the vector unit (port 1), one transaction at a time, round-robin.
// Optional watchdog: define STORAGE_ARB_TIMEOUT_EN to abort a stalled ISSUE
// after TIMEOUT_CYCLES cycles and return err = 1 to the winner.
//
//   state | meaning
//   IDLE  | no transaction; arbitrate and latch the winner's request
//   ISSUE | mem_access high, latched request on mem_*, wait for completion
//   RESP  | one-cycle valid pulse with latched data to the winner
module storage_arbiter
  import storage_arb_pkg::*;
#(
  parameter int MEM_W          = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               r0_access,
  input  logic               r0_is_writing,
  input  logic [31:0]        r0_addr,
  input  logic [31:0]        r0_d_in,
  input  logic [MEM_W/8-1:0] r0_be,
  output logic [31:0]        r0_d_out,
  output logic               r0_valid,
  output logic               r0_err,
  input  logic               r1_access,
  input  logic               r1_is_writing,
  input  logic [31:0]        r1_addr,
  input  logic [31:0]        r1_d_in,
  input  logic [MEM_W/8-1:0] r1_be,
  output logic [31:0]        r1_d_out,
  output logic               r1_valid,
  output logic               r1_err,
  output logic               mem_access,
  output logic               mem_is_writing,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_d_in,
  output logic [MEM_W/8-1:0] mem_be,
  input  logic [31:0]        mem_d_out,
  input  logic               mem_out_valid
);

  arb_state_e  state;
  mem_req_t    req_q;
  mem_req_t    cand;
  logic        winner_q;
  logic        gnt_valid;
  logic        gnt_id;
  logic        fin;
  logic [31:0] fin_data;

`ifdef STORAGE_ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_q;
  logic        fin_err;
  logic        r0_err_q;
  logic        r1_err_q;
  assign r0_err = r0_err_q;
  assign r1_err = r1_err_q;
`else
  assign r0_err = 1'b0;
  assign r1_err = 1'b0;
`endif

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       ({r1_access, r0_access}),
    .update_en (state == IDLE),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Downstream request comes only from the latched copy, never the live inputs.
  assign mem_is_writing = req_q.is_writing;
  assign mem_addr       = req_q.addr;
  assign mem_d_in       = req_q.d_in;
  assign mem_be         = req_q.be;

  // Request of whichever port the arbiter is granting this cycle.
  always_comb begin
    if (gnt_id == PORT_VECTOR) begin
      cand = '{is_writing: r1_is_writing, addr: r1_addr, d_in: r1_d_in, be: r1_be};
    end else begin
      cand = '{is_writing: r0_is_writing, addr: r0_addr, d_in: r0_d_in, be: r0_be};
    end
  end

  // Completion decode in ISSUE; a real completion beats a coincident timeout.
  always_comb begin
    fin      = 1'b0;
    fin_data = '0;
`ifdef STORAGE_ARB_TIMEOUT_EN
    fin_err  = 1'b0;
`endif
    if (state == ISSUE) begin
      if (mem_out_valid) begin
        fin      = 1'b1;
        fin_data = req_q.is_writing ? 32'h0 : mem_d_out;
      end
`ifdef STORAGE_ARB_TIMEOUT_EN
      else if (wd_q == WD_LAST) begin
        fin     = 1'b1;
        fin_err = 1'b1;
      end
`endif
    end
  end

  // Arbitration FSM with registered downstream strobe and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_q      <= '0;
      winner_q   <= PORT_SCALAR;
      mem_access <= 1'b0;
      r0_valid   <= 1'b0;
      r1_valid   <= 1'b0;
      r0_d_out   <= '0;
      r1_d_out   <= '0;
`ifdef STORAGE_ARB_TIMEOUT_EN
      wd_q       <= '0;
      r0_err_q   <= 1'b0;
      r1_err_q   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_valid) begin
            req_q      <= cand;
            winner_q   <= gnt_id;
            mem_access <= 1'b1;
            state      <= ISSUE;
`ifdef STORAGE_ARB_TIMEOUT_EN
            wd_q       <= '0;
`endif
          end
        end
        ISSUE: begin
          if (fin) begin
            mem_access <= 1'b0;
            state      <= RESP;
            r0_valid   <= (winner_q == PORT_SCALAR);
            r1_valid   <= (winner_q == PORT_VECTOR);
            r0_d_out   <= (winner_q == PORT_SCALAR) ? fin_data : 32'h0;
            r1_d_out   <= (winner_q == PORT_VECTOR) ? fin_data : 32'h0;
`ifdef STORAGE_ARB_TIMEOUT_EN
            r0_err_q   <= (winner_q == PORT_SCALAR) && fin_err;
            r1_err_q   <= (winner_q == PORT_VECTOR) && fin_err;
`endif
          end
`ifdef STORAGE_ARB_TIMEOUT_EN
          else begin
            wd_q <= wd_q + 16'd1;
          end
`endif
        end
        RESP: begin
          r0_valid <= 1'b0;
          r1_valid <= 1'b0;
          r0_d_out <= '0;
          r1_d_out <= '0;
`ifdef STORAGE_ARB_TIMEOUT_EN
          r0_err_q <= 1'b0;
          r1_err_q <= 1'b0;
`endif
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_storage_arbiter.sv
// Directed bench for storage_arbiter. Expected responses are queued when the
// memory completion is driven and checked when a requester valid appears.
module tb_storage_arbiter;

  localparam int MEM_W = 32;
  localparam int BE_W  = MEM_W / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            r0_access, r0_is_writing, r1_access, r1_is_writing;
  logic [31:0]     r0_addr, r0_d_in, r1_addr, r1_d_in;
  logic [BE_W-1:0] r0_be, r1_be, mem_be;
  logic [31:0]     r0_d_out, r1_d_out;
  logic            r0_valid, r1_valid, r0_err, r1_err;
  logic            mem_access, mem_is_writing, mem_out_valid;
  logic [31:0]     mem_addr, mem_d_in, mem_d_out;

  typedef struct {
    logic        port;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   valid_cnt  = 0;
  int   push_cnt   = 0;
  int   vc_snap;

  always #5 clk = ~clk;

  storage_arbiter #(.MEM_W(MEM_W), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .r0_access(r0_access), .r0_is_writing(r0_is_writing), .r0_addr(r0_addr),
    .r0_d_in(r0_d_in), .r0_be(r0_be), .r0_d_out(r0_d_out), .r0_valid(r0_valid),
    .r0_err(r0_err),
    .r1_access(r1_access), .r1_is_writing(r1_is_writing), .r1_addr(r1_addr),
    .r1_d_in(r1_d_in), .r1_be(r1_be), .r1_d_out(r1_d_out), .r1_valid(r1_valid),
    .r1_err(r1_err),
    .mem_access(mem_access), .mem_is_writing(mem_is_writing), .mem_addr(mem_addr),
    .mem_d_in(mem_d_in), .mem_be(mem_be), .mem_d_out(mem_d_out),
    .mem_out_valid(mem_out_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic p, input logic acc, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input logic [BE_W-1:0] be);
    if (p == 1'b0) begin
      r0_access = acc; r0_is_writing = wr; r0_addr = a; r0_d_in = d; r0_be = be;
    end else begin
      r1_access = acc; r1_is_writing = wr; r1_addr = a; r1_d_in = d; r1_be = be;
    end
  endtask

  // Called inside the first ISSUE cycle; completion arrives 'delay' cycles later.
  // Returns at the falling edge of the RESP cycle.
  task automatic mem_reply(input int delay, input logic port, input logic wr, input logic [31:0] rd);
    repeat (delay) step();
    mem_out_valid = 1'b1;
    mem_d_out     = rd;
    exp_q.push_back('{port: port, data: (wr ? 32'h0 : rd), err: 1'b0});
    push_cnt++;
    step();
    mem_out_valid = 1'b0;
    mem_d_out     = 32'h0;
    @(negedge clk);
    check("resp_valid", 32'(port ? r1_valid : r0_valid), 32'd1);
    check("resp_mem_access_low", 32'(mem_access), 32'd0);
  endtask

  // Scoreboard: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (r0_valid || r1_valid) begin
      exp_t e;
      valid_cnt++;
      check("valid_one_hot", 32'(r0_valid & r1_valid), 32'd0);
      check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_port", 32'(r1_valid), 32'(e.port));
        check("sb_data", r1_valid ? r1_d_out : r0_d_out, e.data);
        check("sb_err", 32'(r1_valid ? r1_err : r0_err), 32'(e.err));
        check("sb_loser_d_out", r1_valid ? r0_d_out : r1_d_out, 32'h0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, '0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, '0);
    mem_out_valid = 1'b0;
    mem_d_out     = 32'h0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_mem_access", 32'(mem_access), 32'd0);
    check("rst_r0_valid", 32'(r0_valid), 32'd0);
    check("rst_r1_valid", 32'(r1_valid), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_be", 32'(mem_be), 32'h0);
    check("rst_r0_d_out", r0_d_out, 32'h0);
    rst = 1'b0;
    step();

    // Simultaneous requests after reset: port 0 first, then port 1 on the next IDLE
    set_req(1'b0, 1'b1, 1'b1, 32'h200, 32'h11, 4'hF);
    set_req(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
    step();
    @(negedge clk);
    check("c1_mem_access", 32'(mem_access), 32'd1);
    check("c1_mem_addr", mem_addr, 32'h200);
    check("c1_mem_wr", 32'(mem_is_writing), 32'd1);
    check("c1_mem_d_in", mem_d_in, 32'h11);
    mem_reply(0, 1'b0, 1'b1, 32'hAAAA5555);
    r0_access = 1'b0;
    step();
    @(negedge clk);
    check("c2_idle_gap", 32'(mem_access), 32'd0);
    step();
    @(negedge clk);
    check("c2_mem_access", 32'(mem_access), 32'd1);
    check("c2_mem_addr", mem_addr, 32'h300);
    check("c2_mem_wr", 32'(mem_is_writing), 32'd0);
    mem_reply(1, 1'b1, 1'b0, 32'h12345678);
    r1_access = 1'b0;
    step();
    @(negedge clk);
    check("c2_valid_pulse_end", 32'(r1_valid), 32'd0);

    // Single read on port 0; the winner changes its address during ISSUE
    set_req(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    step();
    @(negedge clk);
    check("s_mem_access", 32'(mem_access), 32'd1);
    check("s_mem_addr", mem_addr, 32'h100);
    r0_addr = 32'h999;
    step();
    @(negedge clk);
    check("s_addr_hold", mem_addr, 32'h100);
    mem_reply(1, 1'b0, 1'b0, 32'hDEADBEEF);
    check("s_r1_quiet", 32'(r1_valid), 32'd0);
    r0_access = 1'b0;
    step();
    @(negedge clk);
    check("s_valid_pulse_end", 32'(r0_valid), 32'd0);

    // Pointer now favours port 1 (last grant went to port 0)
    set_req(1'b0, 1'b1, 1'b0, 32'h400, 32'h0, 4'hF);
    set_req(1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 4'hF);
    step();
    @(negedge clk);
    check("p_first_addr", mem_addr, 32'h500);
    mem_reply(0, 1'b1, 1'b0, 32'h5555);
    r1_access = 1'b0;
    step();
    step();
    @(negedge clk);
    check("p_second_addr", mem_addr, 32'h400);
    mem_reply(0, 1'b0, 1'b0, 32'h4444);
    r0_access = 1'b0;
    step();

    // Back-to-back port 1 writes with partial byte enables
    set_req(1'b1, 1'b1, 1'b1, 32'h600, 32'hCAFE0001, 4'b0011);
    step();
    @(negedge clk);
    check("b1_mem_be", 32'(mem_be), 32'h3);
    check("b1_mem_addr", mem_addr, 32'h600);
    check("b1_mem_d_in", mem_d_in, 32'hCAFE0001);
    mem_reply(0, 1'b1, 1'b1, 32'hFFFF);
    set_req(1'b1, 1'b1, 1'b1, 32'h604, 32'hCAFE0002, 4'b0011);
    step();
    @(negedge clk);
    check("b2_idle", 32'(mem_access), 32'd0);
    step();
    @(negedge clk);
    check("b2_mem_access", 32'(mem_access), 32'd1);
    check("b2_mem_addr", mem_addr, 32'h604);
    check("b2_mem_be", 32'(mem_be), 32'h3);
    check("b2_mem_d_in", mem_d_in, 32'hCAFE0002);
    mem_reply(0, 1'b1, 1'b1, 32'h0);
    r1_access = 1'b0;
    step();

    // Stalled memory on port 0
    set_req(1'b0, 1'b1, 1'b0, 32'h700, 32'h0, 4'hF);
    step();
`ifdef STORAGE_ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("to_issue_access", 32'(mem_access), 32'd1);
      check("to_no_valid", 32'(r0_valid), 32'd0);
      if (i == 7) begin
        exp_q.push_back('{port: 1'b0, data: 32'h0, err: 1'b1});
        push_cnt++;
      end
      step();
    end
    @(negedge clk);
    check("to_valid", 32'(r0_valid), 32'd1);
    check("to_err", 32'(r0_err), 32'd1);
    check("to_access_low", 32'(mem_access), 32'd0);
    r0_access = 1'b0;
    step();
    set_req(1'b0, 1'b1, 1'b0, 32'h710, 32'h0, 4'hF);
    step();
    @(negedge clk);
`else
    vc_snap = valid_cnt;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("hold_issue_access", 32'(mem_access), 32'd1);
    end
    check("hold_no_valid", 32'(valid_cnt), 32'(vc_snap));
`endif

    // Reset while in ISSUE
    check("pre_rst_access", 32'(mem_access), 32'd1);
    vc_snap = valid_cnt;
    rst = 1'b1;
    #1;
    check("rst_async_access", 32'(mem_access), 32'd0);
    r0_access = 1'b0;
    r1_access = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
    step();
    check("rst_no_valid", 32'(valid_cnt), 32'(vc_snap));
    // Pointer back at port 0 after reset
    set_req(1'b0, 1'b1, 1'b0, 32'h800, 32'h0, 4'hF);
    set_req(1'b1, 1'b1, 1'b0, 32'h900, 32'h0, 4'hF);
    step();
    @(negedge clk);
    check("rst_ptr_first", mem_addr, 32'h800);
    mem_reply(0, 1'b0, 1'b0, 32'h8080);
    r0_access = 1'b0;
    step();
    step();
    @(negedge clk);
    check("rst_ptr_second", mem_addr, 32'h900);
    mem_reply(0, 1'b1, 1'b0, 32'h9090);
    r1_access = 1'b0;
    step();
    step();

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("valid_count", 32'(valid_cnt), 32'(push_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
